// File: rtl/datapath_seq_ctrl_if.sv
// Instruction-fetch handshake and datapath control bundle between the
// sequencer (master) and the memory/register-file/ALU side (slave).
interface datapath_seq_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_valid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  EQ;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  logic                  RegWrite;
  logic                  ALUsrc;
  logic                  ALUctrl;
  logic [DATA_WIDTH-1:0] ImmOp;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata, EQ,
    output rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata, EQ,
    input  rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp
  );
endinterface

// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle sequencer for the register-file/ALU datapath: fetches, decodes and
// executes addi/add/bne one at a time; any other encoding halts the core.
module datapath_seq_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  datapath_seq_ctrl_if.master   bus,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] retired,
  output logic                  halted
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ILL  = 2'd0,
    OP_ADDI = 2'd1,
    OP_ADD  = 2'd2,
    OP_BNE  = 2'd3
  } op_e;

  localparam logic [DATA_WIDTH-1:0] PC_STEP  = {{(DATA_WIDTH-3){1'b0}}, 3'b100};
  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};

  function automatic op_e classify(input logic [31:0] w);
    case (w[6:0])
      7'b0010011: classify = (w[14:12] == 3'b000) ? OP_ADDI : OP_ILL;
      7'b0110011: classify = ((w[14:12] == 3'b000) && (w[31:25] == 7'b0000000)) ? OP_ADD : OP_ILL;
      7'b1100011: classify = (w[14:12] == 3'b001) ? OP_BNE : OP_ILL;
      default:    classify = OP_ILL;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] imm_of(input op_e op, input logic [31:0] w);
    case (op)
      OP_ADDI: imm_of = {{(DATA_WIDTH-12){w[31]}}, w[31:20]};
      OP_BNE:  imm_of = {{(DATA_WIDTH-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: imm_of = {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  state_e                state_r, state_nxt_s;
  op_e                   fetch_op_s, dec_op_s;
  logic                  fetch_done_s;
  logic [DATA_WIDTH-1:0] pc_r, pc_nxt_s, retired_r, ir_r, immop_r;
  logic [ADDR_WIDTH-1:0] rs1_r, rs2_r, rd_r;
  logic                  imem_req_r, reg_write_r, alusrc_r, aluctrl_r, halted_r;

  // Next-state and next-PC selection
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    fetch_done_s = 1'b0;
    fetch_op_s   = classify(bus.imem_rdata[31:0]);
    dec_op_s     = classify(ir_r[31:0]);
    case (state_r)
      ST_IDLE: begin
        if (run) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.imem_valid) begin
          state_nxt_s  = ST_DECODE;
          fetch_done_s = 1'b1;
        end else begin
          state_nxt_s  = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_op_s == OP_ILL) state_nxt_s = ST_HALT;
        else                    state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        // Branch taken only when the datapath reports the operands differ
        if ((dec_op_s == OP_BNE) && !bus.EQ) pc_nxt_s = pc_r + immop_r;
        else                                 pc_nxt_s = pc_r + PC_STEP;
        if (run) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_IDLE;
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Architectural state and registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      retired_r   <= ZERO;
      ir_r        <= ZERO;
      imem_req_r  <= 1'b0;
      reg_write_r <= 1'b0;
      alusrc_r    <= 1'b0;
      aluctrl_r   <= 1'b0;
      immop_r     <= ZERO;
      rs1_r       <= REG_ZERO;
      rs2_r       <= REG_ZERO;
      rd_r        <= REG_ZERO;
      halted_r    <= 1'b0;
    end else begin
      imem_req_r  <= (state_nxt_s == ST_FETCH);
      halted_r    <= (state_nxt_s == ST_HALT);
      reg_write_r <= (state_nxt_s == ST_EXEC) && (dec_op_s != OP_BNE) && (rd_r != REG_ZERO);
      if (state_r == ST_EXEC) begin
        pc_r      <= pc_nxt_s;
        retired_r <= retired_r + ONE;
      end
      // Operand fields are captured with the instruction so they are valid
      // throughout DECODE, held across EXEC and cleared afterwards.
      if (fetch_done_s) begin
        ir_r      <= bus.imem_rdata;
        rs1_r     <= ADDR_WIDTH'(bus.imem_rdata[19:15]);
        rs2_r     <= ADDR_WIDTH'(bus.imem_rdata[24:20]);
        rd_r      <= ADDR_WIDTH'(bus.imem_rdata[11:7]);
        alusrc_r  <= (fetch_op_s == OP_ADDI);
        aluctrl_r <= (fetch_op_s == OP_BNE);
        immop_r   <= imm_of(fetch_op_s, bus.imem_rdata[31:0]);
      end else if (state_nxt_s != ST_EXEC) begin
        rs1_r     <= REG_ZERO;
        rs2_r     <= REG_ZERO;
        rd_r      <= REG_ZERO;
        alusrc_r  <= 1'b0;
        aluctrl_r <= 1'b0;
        immop_r   <= ZERO;
      end
    end
  end

  assign bus.imem_req  = imem_req_r;
  assign bus.imem_addr = pc_r;
  assign bus.rs1       = rs1_r;
  assign bus.rs2       = rs2_r;
  assign bus.rd        = rd_r;
  assign bus.RegWrite  = reg_write_r;
  assign bus.ALUsrc    = alusrc_r;
  assign bus.ALUctrl   = aluctrl_r;
  assign bus.ImmOp     = immop_r;
  assign pc            = pc_r;
  assign retired       = retired_r;
  assign halted        = halted_r;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Scoreboard bench for datapath_seq_ctrl: directed and random instruction
// streams checked against an instruction-level reference model.
module tb_datapath_seq_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret_before;
    logic [31:0] next_pc;
    logic [31:0] next_ret;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    bit          alusrc;
    bit          aluctrl;
    bit          regwrite;
    bit          illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;

  datapath_seq_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  datapath_seq_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .bus     (bus),
    .pc      (pc),
    .retired (retired),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  bit          mon_enable = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: one instruction at a time, straight from the ISA rules
  function automatic exp_t model(input logic [31:0] w, input bit eq_v);
    exp_t e;
    bit   is_addi, is_add, is_bne;
    int   imm;
    is_addi = (w[6:0] == 7'h13) && (w[14:12] == 3'd0);
    is_add  = (w[6:0] == 7'h33) && (w[14:12] == 3'd0) && (w[31:25] == 7'd0);
    is_bne  = (w[6:0] == 7'h63) && (w[14:12] == 3'd1);
    imm = 0;
    if (is_addi) imm = int'(w[31:20]) - (w[31] ? 4096 : 0);
    if (is_bne)  imm = int'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? 8192 : 0);
    e.pc         = m_pc;
    e.ret_before = m_ret;
    e.imm        = 32'(imm);
    e.rs1        = w[19:15];
    e.rs2        = w[24:20];
    e.rd         = w[11:7];
    e.alusrc     = is_addi;
    e.aluctrl    = is_bne;
    e.illegal    = !(is_addi || is_add || is_bne);
    e.regwrite   = (is_addi || is_add) && (w[11:7] != 5'd0);
    e.next_pc    = (is_bne && !eq_v) ? m_pc + 32'(imm) : m_pc + 32'd4;
    e.next_ret   = m_ret + 32'd1;
    return e;
  endfunction

  // Serve one fetch: wait for the request, predict, respond after lat cycles
  task automatic do_instr(input logic [31:0] w, input int lat, input bit eq_v, input bit run_after);
    exp_t e;
    int   n;
    run    = 1'b1;
    bus.EQ = eq_v;
    n = 0;
    while (!bus.imem_req && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.imem_req) begin
      chk("fetch_req_timeout", 32'(bus.imem_req), 32'd1);
      return;
    end
    e = model(w, eq_v);
    if (!e.illegal) begin
      m_pc  = e.next_pc;
      m_ret = e.next_ret;
    end
    exp_q.push_back(e);
    repeat (lat) begin
      @(posedge clk); #1;
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = w;
    @(posedge clk); #1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = $urandom;
    run = run_after;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(2, 0))
      0: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
      1: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'd0; end
      default: begin w[6:0] = 7'h63; w[14:12] = 3'd1; end
    endcase
    if ($urandom_range(7, 0) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // Monitor: pops the scoreboard on every fetch handshake and follows the
  // instruction through DECODE, EXEC and the retire edge
  initial begin : monitor
    exp_t e;
    bit   resample;
    resample = 1'b0;
    forever begin
      if (!resample) @(negedge clk);
      resample = 1'b0;
      if (mon_enable && bus.imem_req) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fetch", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("imem_addr", bus.imem_addr, exp_q[0].pc);
          if (bus.imem_valid) begin
            e = exp_q.pop_front();
            @(negedge clk);
            chk("dec_regwrite", 32'(bus.RegWrite), 32'd0);
            chk("dec_req", 32'(bus.imem_req), 32'd0);
            if (!e.illegal) begin
              chk("dec_rs1", 32'(bus.rs1), 32'(e.rs1));
              chk("dec_rs2", 32'(bus.rs2), 32'(e.rs2));
              chk("dec_rd", 32'(bus.rd), 32'(e.rd));
              chk("dec_alusrc", 32'(bus.ALUsrc), 32'(e.alusrc));
              chk("dec_aluctrl", 32'(bus.ALUctrl), 32'(e.aluctrl));
              chk("dec_immop", bus.ImmOp, e.imm);
            end
            @(negedge clk);
            if (e.illegal) begin
              for (int k = 0; k < 5; k++) begin
                chk("halt_flag", 32'(halted), 32'd1);
                chk("halt_req", 32'(bus.imem_req), 32'd0);
                chk("halt_regwrite", 32'(bus.RegWrite), 32'd0);
                chk("halt_pc", pc, e.pc);
                chk("halt_retired", retired, e.ret_before);
                @(negedge clk);
              end
              resample = 1'b1;
            end else begin
              chk("exec_regwrite", 32'(bus.RegWrite), 32'(e.regwrite));
              chk("exec_rs1", 32'(bus.rs1), 32'(e.rs1));
              chk("exec_rs2", 32'(bus.rs2), 32'(e.rs2));
              chk("exec_rd", 32'(bus.rd), 32'(e.rd));
              chk("exec_alusrc", 32'(bus.ALUsrc), 32'(e.alusrc));
              chk("exec_aluctrl", 32'(bus.ALUctrl), 32'(e.aluctrl));
              chk("exec_immop", bus.ImmOp, e.imm);
              chk("exec_pc", pc, e.pc);
              @(negedge clk);
              chk("next_pc", pc, e.next_pc);
              chk("retired", retired, e.next_ret);
              chk("post_regwrite", 32'(bus.RegWrite), 32'd0);
              chk("not_halted", 32'(halted), 32'd0);
              resample = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    rst            = 1'b1;
    run            = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.EQ         = 1'b0;
    m_pc           = RESET_PC;
    m_ret          = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_immop", bus.ImmOp, 32'd0);
    rst        = 1'b0;
    mon_enable = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_req", 32'(bus.imem_req), 32'd0);

    // Directed sequence from the instruction-level examples
    do_instr(32'h00500513, 0, 1'b0, 1'b1);
    do_instr(32'h00B50533, 3, 1'b0, 1'b1);
    do_instr(32'h00100093, 1, 1'b0, 1'b1);
    do_instr(32'h00208113, 0, 1'b1, 1'b1);
    do_instr(32'hFE051EE3, 2, 1'b0, 1'b1);
    do_instr(32'h00000013, 0, 1'b1, 1'b1);
    do_instr(32'hFE051EE3, 1, 1'b1, 1'b1);
    do_instr(32'h00000013, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("paused_no_req", 32'(bus.imem_req), 32'd0);

    for (int i = 0; i < 60; i++) begin
      do_instr(rand_instr(), int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)),
               ($urandom_range(4, 0) != 0));
      if (!run) repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end

    // Reset while a fetch is outstanding, with a late imem_valid afterwards
    mon_enable = 1'b0;
    run = 1'b1;
    n = 0;
    while (!bus.imem_req && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("pend_req", 32'(bus.imem_req), 32'd1);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h00500513;
    rst = 1'b1;
    run = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.imem_req), 32'd0);
    chk("async_rst_pc", pc, RESET_PC);
    chk("async_rst_retired", retired, 32'd0);
    chk("async_rst_rd", 32'(bus.rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("late_valid_req", 32'(bus.imem_req), 32'd0);
      chk("late_valid_pc", pc, RESET_PC);
      chk("late_valid_retired", retired, 32'd0);
    end
    bus.imem_valid = 1'b0;
    exp_q.delete();
    m_pc       = RESET_PC;
    m_ret      = 32'd0;
    mon_enable = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_instr(rand_instr(), int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), 1'b1);
    end
    do_instr(32'hFFFFFFFF, 1, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
